vdp_cpu_port: RTL and testbench

- CPU-side responder for the TMS9918-compatible VDP I/O pair: data port (0x98) and control port (0x99).
- Decodes Z80 I/O accesses and runs the two-byte control sequence: VRAM address setup or register write.
- Sole VRAM master for CPU traffic, via a req/ack handshake with the video block. Owns the read-ahead buffer, the status register and the interrupt line.
- Sits between the tv80n bus decode and the video block; the top level replaces its inline VDP decode with this block.

---
 rtl/vdp_pkg.sv | 26 ++
 rtl/vdp_status.sv | 52 +++++
 rtl/vdp_cpu_port.sv | 177 +++++++++++++++++
 tb/tb_vdp_cpu_port.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/vdp_pkg.sv
// Shared types and constants for the VDP CPU port.
// VDP_EXT_REGS_EN widens the register file from 8 to 16 entries.
package vdp_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WR   = 2'd1,
    RD   = 2'd2
  } vram_state_t;

  localparam logic [1:0] CMD_RD_SETUP = 2'b00;
  localparam logic [1:0] CMD_WR_SETUP = 2'b01;

  localparam int ST_F  = 7;
  localparam int ST_5S = 6;
  localparam int ST_C  = 5;

`ifdef VDP_EXT_REGS_EN
  localparam int NUM_REGS = 16;
`else
  localparam int NUM_REGS = 8;
`endif
  localparam int MAX_REGS = 16;
  localparam int RIDX_W   = $clog2(NUM_REGS);

endpackage

// File: rtl/vdp_status.sv
// Status latches (F, 5S, C, fifth sprite number) and the interrupt line.
// A set event in the same cycle as a read-clear wins.
module vdp_status
  import vdp_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       vblank_evt,
  input  logic       coll_evt,
  input  logic       fifth_evt,
  input  logic [4:0] fifth_num,
  input  logic       clr,
  input  logic       int_en,
  output logic [7:0] status,
  output logic       n_int
);

  logic       f_q;
  logic       s5_q;
  logic       c_q;
  logic [4:0] num_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      f_q   <= 1'b0;
      s5_q  <= 1'b0;
      c_q   <= 1'b0;
      num_q <= 5'd0;
    end else begin
      f_q <= vblank_evt | (f_q & ~clr);
      c_q <= coll_evt | (c_q & ~clr);
      // only the first fifth-sprite event since the last clear is kept
      if (fifth_evt && (!s5_q || clr)) begin
        s5_q  <= 1'b1;
        num_q <= fifth_num;
      end else if (clr) begin
        s5_q <= 1'b0;
      end
    end
  end

  always_comb begin
    status        = 8'h00;
    status[ST_F]  = f_q;
    status[ST_5S] = s5_q;
    status[ST_C]  = c_q;
    status[4:0]   = s5_q ? num_q : 5'h1F;
  end

  assign n_int = ~(f_q & int_en);

endmodule

// File: rtl/vdp_cpu_port.sv
// CPU-side responder for the VDP data/control port pair and sole CPU VRAM master.
// Register file size follows VDP_EXT_REGS_EN (see vdp_pkg).
//
// state | meaning
// IDLE  | no VRAM operation outstanding
// WR    | write request held until ack
// RD    | read request held until ack, buffer loads on ack
module vdp_cpu_port
  import vdp_pkg::*;
#(
  parameter int ADDR_W         = 14,
  parameter bit WRITE_PREFETCH = 1'b0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clk_ena,
  input  logic              io_rd,
  input  logic              io_wr,
  input  logic              port_sel,
  input  logic [7:0]        din,
  output logic [7:0]        dout,
  output logic              wait_n,
  output logic              vram_req,
  output logic              vram_we,
  output logic [ADDR_W-1:0] vram_addr,
  output logic [7:0]        vram_wdata,
  input  logic              vram_ack,
  input  logic [7:0]        vram_rdata,
  input  logic              vblank_evt,
  input  logic              coll_evt,
  input  logic              fifth_evt,
  input  logic [4:0]        fifth_num,
  output logic [127:0]      vdp_regs,
  output logic              n_int
);

  vram_state_t state, state_nx;

  logic              prev_act, stalled, latch_flag, rd_pend, ctrl_rd_pend;
  logic [7:0]        first_byte, rbuf, wdata_q;
  logic [ADDR_W-1:0] addr;
  logic [7:0]        regs [NUM_REGS];
  logic [7:0]        status;

  logic              active, start, acc_end, busy, process;
  logic              launch_wr, launch_rd, addr_setup, reg_we, reg_ok;
  logic [RIDX_W-1:0] reg_idx;

  assign active  = io_rd | io_wr;
  assign start   = clk_ena & active & ~prev_act;
  assign acc_end = clk_ena & ~active & prev_act;
  assign busy    = (state != IDLE);
  // a stalled access is replayed as soon as the FSM is back in IDLE
  assign process = ~busy & (start | (stalled & active));
  assign wait_n  = ~(busy & (start | stalled));

  assign reg_idx    = din[RIDX_W-1:0];
  assign reg_ok     = (din[6:RIDX_W] == '0);
  assign addr_setup = process & io_wr & port_sel & latch_flag & ~din[7];
  assign reg_we     = process & io_wr & port_sel & latch_flag & din[7] & reg_ok;
  assign launch_wr  = process & io_wr & ~port_sel;
  // data-read fetch is deferred to access end so dout stays stable during the read
  assign launch_rd  = (addr_setup & ((din[7:6] == CMD_RD_SETUP) | WRITE_PREFETCH))
                    | (acc_end & rd_pend);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    vram_req = 1'b0;
    vram_we  = 1'b0;
    case (state)
      IDLE: begin
        if (launch_wr)      state_nx = WR;
        else if (launch_rd) state_nx = RD;
      end
      WR: begin
        vram_req = 1'b1;
        vram_we  = 1'b1;
        if (vram_ack) state_nx = IDLE;
      end
      RD: begin
        vram_req = 1'b1;
        if (vram_ack) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prev_act     <= 1'b0;
      stalled      <= 1'b0;
      latch_flag   <= 1'b0;
      rd_pend      <= 1'b0;
      ctrl_rd_pend <= 1'b0;
      first_byte   <= 8'h00;
      rbuf         <= 8'h00;
      wdata_q      <= 8'h00;
      addr         <= '0;
    end else begin
      if (clk_ena) prev_act <= active;
      if (busy && start)          stalled <= 1'b1;
      else if (process || !active) stalled <= 1'b0;

      if (acc_end) begin
        rd_pend      <= 1'b0;
        ctrl_rd_pend <= 1'b0;
        if (ctrl_rd_pend) latch_flag <= 1'b0;
      end

      if (process) begin
        if (!port_sel) begin
          latch_flag <= 1'b0;
          if (io_wr) begin
            wdata_q <= din;
            rbuf    <= din;
          end else begin
            rd_pend <= 1'b1;
          end
        end else if (io_wr) begin
          if (!latch_flag) begin
            first_byte <= din;
            latch_flag <= 1'b1;
          end else begin
            latch_flag <= 1'b0;
            if (!din[7]) addr <= ADDR_W'({din[5:0], first_byte});
          end
        end else begin
          ctrl_rd_pend <= 1'b1;
        end
      end

      if (busy && vram_ack) begin
        addr <= addr + ADDR_W'(1);
        if (state == RD) rbuf <= vram_rdata;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= 8'h00;
    end else if (reg_we) begin
      regs[reg_idx] <= first_byte;
    end
  end

  for (genvar i = 0; i < MAX_REGS; i++) begin : g_regs
    if (i < NUM_REGS) begin : g_live
      assign vdp_regs[8*i +: 8] = regs[i];
    end else begin : g_tie
      assign vdp_regs[8*i +: 8] = 8'h00;
    end
  end

  vdp_status u_status (
    .clk        (clk),
    .reset      (reset),
    .vblank_evt (vblank_evt),
    .coll_evt   (coll_evt),
    .fifth_evt  (fifth_evt),
    .fifth_num  (fifth_num),
    .clr        (acc_end & ctrl_rd_pend),
    .int_en     (regs[1][5]),
    .status     (status),
    .n_int      (n_int)
  );

  assign dout       = io_rd ? (port_sel ? status : rbuf) : 8'h00;
  assign vram_addr  = addr;
  assign vram_wdata = wdata_q;

endmodule

// File: tb/tb_vdp_cpu_port.sv
// Scoreboard bench for vdp_cpu_port: a port-level model predicts VRAM operations
// and CPU read data; monitors compare whatever the DUT presents.
module tb_vdp_cpu_port;

  logic         clk = 1'b0, reset = 1'b1, clk_ena = 1'b0;
  logic         io_rd = 1'b0, io_wr = 1'b0, port_sel = 1'b0;
  logic [7:0]   din = 8'h00;
  logic [7:0]   dout;
  logic         wait_n, vram_req, vram_we;
  logic [13:0]  vram_addr;
  logic [7:0]   vram_wdata;
  logic         vram_ack = 1'b0;
  logic [7:0]   vram_rdata = 8'h00;
  logic         vblank_evt = 1'b0, coll_evt = 1'b0, fifth_evt = 1'b0;
  logic [4:0]   fifth_num = 5'd0;
  logic [127:0] vdp_regs;
  logic         n_int;

  vdp_cpu_port dut (
    .clk(clk), .reset(reset), .clk_ena(clk_ena), .io_rd(io_rd), .io_wr(io_wr),
    .port_sel(port_sel), .din(din), .dout(dout), .wait_n(wait_n),
    .vram_req(vram_req), .vram_we(vram_we), .vram_addr(vram_addr),
    .vram_wdata(vram_wdata), .vram_ack(vram_ack), .vram_rdata(vram_rdata),
    .vblank_evt(vblank_evt), .coll_evt(coll_evt), .fifth_evt(fifth_evt),
    .fifth_num(fifth_num), .vdp_regs(vdp_regs), .n_int(n_int)
  );

  always #5 clk = ~clk;
  initial forever begin @(posedge clk); #2 clk_ena = ~clk_ena; end

  typedef struct { bit we; logic [13:0] addr; logic [7:0] data; } vop_t;
  vop_t       exp_vq[$];
  logic [7:0] exp_rq[$];
  int checks = 0, errors = 0;
  int ack_delay = 0, dly_cnt = 0, stall_cnt = 0;

  // reference model: the port as seen by the CPU
  logic [7:0] m_vram [16384];
  logic [7:0] tb_vram [16384];
  int         m_addr = 0;
  logic [7:0] m_buf = 8'h00, m_first = 8'h00;
  bit         m_latch = 0, m_f = 0, m_s5 = 0, m_c = 0;
  logic [4:0] m_num = 5'd0;
  logic [7:0] m_regs [8];

  function automatic logic [7:0] m_status();
    return {m_f, m_s5, m_c, (m_s5 ? m_num : 5'h1F)};
  endfunction

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic m_fetch();
    exp_vq.push_back(vop_t'{1'b0, 14'(m_addr), 8'h00});
    m_buf  = m_vram[m_addr];
    m_addr = (m_addr + 1) % 16384;
  endtask

  task automatic cpu_access(input bit rd, input bit port, input logic [7:0] d,
                            input bit end_vb);
    int good = 0;
    int guard = 0;
    @(negedge clk);
    io_rd = rd; io_wr = !rd; port_sel = port; din = d;
    while (good < 2) begin
      #1;
      if (clk_ena && wait_n) good++;
      @(negedge clk);
      guard++;
      if (guard > 300) begin
        checks++; errors++;
        $display("FAIL access_timeout: got wait_n=%0b expected release within 300 cycles", wait_n);
        break;
      end
    end
    io_rd = 1'b0; io_wr = 1'b0;
    forever begin
      #1;
      if (clk_ena) begin vblank_evt = end_vb; break; end
      @(negedge clk);
    end
    @(negedge clk);
    vblank_evt = 1'b0;
  endtask

  task automatic data_wr(input logic [7:0] d);
    exp_vq.push_back(vop_t'{1'b1, 14'(m_addr), d});
    m_vram[m_addr] = d;
    m_buf   = d;
    m_addr  = (m_addr + 1) % 16384;
    m_latch = 0;
    cpu_access(1'b0, 1'b0, d, 1'b0);
  endtask

  task automatic data_rd();
    exp_rq.push_back(m_buf);
    m_latch = 0;
    m_fetch();
    cpu_access(1'b1, 1'b0, 8'h00, 1'b0);
  endtask

  task automatic ctrl_wr(input logic [7:0] d);
    if (!m_latch) begin
      m_first = d;
      m_latch = 1;
    end else begin
      m_latch = 0;
      if (d[7] == 1'b0) begin
        m_addr = {d[5:0], m_first};
        if (d[6] == 1'b0) m_fetch();
      end else if (d[6:3] == 4'd0) begin
        m_regs[d[2:0]] = m_first;
      end
    end
    cpu_access(1'b0, 1'b1, d, 1'b0);
  endtask

  task automatic ctrl_rd(input bit end_vb);
    exp_rq.push_back(m_status());
    m_f = 0; m_s5 = 0; m_c = 0; m_latch = 0;
    if (end_vb) m_f = 1;
    cpu_access(1'b1, 1'b1, 8'h00, end_vb);
  endtask

  task automatic evt(input bit vb, input bit co, input bit fi, input logic [4:0] num);
    if (vb) m_f = 1;
    if (co) m_c = 1;
    if (fi && !m_s5) begin m_s5 = 1; m_num = num; end
    @(negedge clk);
    vblank_evt = vb; coll_evt = co; fifth_evt = fi; fifth_num = num;
    @(negedge clk);
    vblank_evt = 1'b0; coll_evt = 1'b0; fifth_evt = 1'b0;
  endtask

  // video-block responder backed by its own VRAM image
  initial forever begin
    @(negedge clk);
    if (vram_ack) begin
      vram_ack = 1'b0;
    end else if (vram_req && !reset) begin
      if (dly_cnt >= ack_delay) begin
        dly_cnt  = 0;
        vram_ack = 1'b1;
        if (vram_we) tb_vram[vram_addr] = vram_wdata;
        else         vram_rdata = tb_vram[vram_addr];
      end else begin
        dly_cnt++;
      end
    end
  end

  // monitors: pop and compare when the DUT presents a request or read data
  initial begin
    bit   req_taken = 0, rd_taken = 0;
    vop_t e;
    forever begin
      @(negedge clk);
      #3;
      if (reset) continue;
      if (!wait_n) stall_cnt++;
      if (vram_req && !req_taken) begin
        req_taken = 1;
        if (exp_vq.size() == 0) begin
          checks++; errors++;
          $display("FAIL vram_unexpected: got addr 0x%0h we %0b expected no request", vram_addr, vram_we);
        end else begin
          e = exp_vq.pop_front();
          check("vram_op", {vram_we, vram_addr, (vram_we ? vram_wdata : 8'h00)},
                {e.we, e.addr, (e.we ? e.data : 8'h00)});
        end
      end
      if (!vram_req) req_taken = 0;
      if (io_rd && clk_ena && wait_n && !rd_taken) begin
        rd_taken = 1;
        if (exp_rq.size() == 0) begin
          checks++; errors++;
          $display("FAIL cpu_rd_unexpected: got 0x%0h expected no read", dout);
        end else begin
          check(port_sel ? "cpu_rd_status" : "cpu_rd_data", dout, exp_rq.pop_front());
        end
      end
      if (!io_rd) rd_taken = 0;
    end
  end

  initial begin
    logic [7:0] v, h;
    int w;
    for (int i = 0; i < 16384; i++) begin
      v = 8'($urandom);
      tb_vram[i] = v;
      m_vram[i]  = v;
    end
    tb_vram[14'h1200] = 8'h5C;
    m_vram[14'h1200]  = 8'h5C;
    for (int i = 0; i < 8; i++) m_regs[i] = 8'h00;

    repeat (3) @(negedge clk);
    check("rst_dout", dout, 8'h00);
    check("rst_wait_n", wait_n, 1);
    check("rst_vram_req", vram_req, 0);
    check("rst_n_int", n_int, 1);
    check("rst_regs_nonzero", (vdp_regs != '0), 0);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    ctrl_wr(8'h34); ctrl_wr(8'h52);
    data_wr(8'hAA); data_wr(8'h11);
    ctrl_wr(8'h00); ctrl_wr(8'h12);
    data_rd();

    ctrl_wr(8'hE0); ctrl_wr(8'h81);
    evt(1, 0, 0, 5'd0);
    check("n_int_after_vblank", n_int, 0);
    ctrl_rd(0);
    check("n_int_after_clear", n_int, 1);
    ctrl_rd(0);

    evt(0, 0, 1, 5'd7);
    evt(0, 0, 1, 5'd9);
    ctrl_rd(1);
    check("n_int_set_wins", n_int, 0);
    ctrl_rd(0);
    ctrl_rd(0);

    ctrl_wr(8'hFF); ctrl_wr(8'h7F);
    ack_delay = 6;
    stall_cnt = 0;
    data_wr(8'hA1); data_wr(8'hB2);
    check("stall_seen", (stall_cnt > 0), 1);
    ack_delay = 0;

    ctrl_wr(8'h55);
    data_rd();
    ctrl_wr(8'h00); ctrl_wr(8'h13);
    data_rd();

    for (int n = 0; n < 80; n++) begin
      ack_delay = $urandom_range(0, 3);
      case ($urandom_range(0, 6))
        0, 1: data_wr(8'($urandom));
        2: data_rd();
        3: begin
          h = {1'b0, 1'($urandom_range(0, 1)), 6'($urandom)};
          ctrl_wr(8'($urandom));
          ctrl_wr(h);
        end
        4: begin
          h = 8'h80 | 8'($urandom_range(0, 7));
          if ($urandom_range(0, 3) == 0) h = h | 8'($urandom_range(1, 15) << 3);
          ctrl_wr(8'($urandom));
          ctrl_wr(h);
        end
        5: ctrl_rd(0);
        default: evt(1'($urandom), 1'($urandom), 1'($urandom), 5'($urandom));
      endcase
    end
    ctrl_rd(0);

    w = 0;
    while ((exp_vq.size() != 0 || exp_rq.size() != 0) && w < 500) begin
      @(negedge clk);
      w++;
    end
    check("scoreboard_drained", exp_vq.size() + exp_rq.size(), 0);
    for (int i = 0; i < 8; i++) check("vdp_reg", vdp_regs[8*i +: 8], m_regs[i]);
    check("regs_hi_nonzero", (vdp_regs[127:64] != '0), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
